// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-read-port general-purpose register file for the
// MiniMIPS32 decode stage.
//
// After reset a clear engine walks every register and zeroes it, one per
// cycle, while `busy` is high. Once idle, the file accepts one write per
// cycle (r0 is hard-wired to zero) and serves NRD independent combinational
// read ports. A per-register pending bit records destinations of issued
// instructions that have not yet written back, so decode can spot operands
// that are not ready.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined     -> a read of the address being written this cycle returns
//                  `wd` and reports the operand as not pending.
//   not defined -> such a read returns the stored value and stored pend bit.
//
// Parameters:
//   DATA_W  register width in bits
//   ADDR_W  register address width; DEPTH = 2**ADDR_W registers
//   NRD     number of read ports (1..4)
//
// Ports:
//   cpu_clk_50M  in   clock, all state updates on the rising edge
//   cpu_rst_n    in   synchronous active-low reset
//   we/wa/wd     in   write enable, address, data
//   ra           in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   re           in   read enables, bit i for port i
//   rd           out  read data, port i at [i*DATA_W +: DATA_W]
//   rd_pend      out  port i's operand has an outstanding producer
//   issue_en     in   an instruction writing issue_wa has been issued
//   issue_wa     in   destination register of the issued instruction
//   busy         out  clear engine active; file unusable
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [NRD*ADDR_W-1:0] ra,
    input  logic [NRD-1:0]        re,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_pend,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_wa,
    output logic                  busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              idle;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;

    assign idle  = (state_q == ST_IDLE);
    assign busy  = ~idle;
    // Writes to r0 are dropped here so r0 can never hold anything but zero.
    assign wr_en = idle && we && (wa != '0);

    // -----------------------------------------------------------------------
    // Next-state logic: clear sequencing and pending-write scoreboard.
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pend_d    = pend_q;

        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
            end
        end else begin
            // Write-back clears first, then issue sets, so a same-cycle
            // issue to the same register leaves the bit set.
            if (we) begin
                pend_d[wa] = 1'b0;
            end
            if (issue_en && (issue_wa != '0)) begin
                pend_d[issue_wa] = 1'b1;
            end
        end

        pend_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pend_q    <= pend_d;
        end
    end

    // NOTE: the storage array has no reset term; it is zeroed by the clear
    // engine one entry per cycle, which keeps it mappable to plain RAM/flops
    // without a DEPTH-wide reset fan-out. Reset itself leaves contents intact.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n) begin
            if (!idle) begin
                regs_q[clr_idx_q] <= '0;
            end else if (wr_en) begin
                regs_q[wa] <= wd;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. Busy, reset, a disabled port and r0 all force zero data
    // and a clear pend flag.
    // -----------------------------------------------------------------------
    always_comb begin
        rd      = '0;
        rd_pend = '0;
        rd_addr = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr = ra[i*ADDR_W +: ADDR_W];
            if (idle && cpu_rst_n && re[i] && (rd_addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (we && (wa == rd_addr)) begin
                    // Forwarded value is the producer's result: not pending.
                    rd[i*DATA_W +: DATA_W] = wd;
                end else begin
                    rd[i*DATA_W +: DATA_W] = regs_q[rd_addr];
                    rd_pend[i]             = pend_q[rd_addr];
                end
`else
                rd[i*DATA_W +: DATA_W] = regs_q[rd_addr];
                rd_pend[i]             = pend_q[rd_addr];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (NRD=4).
// Expected values are queued as stimulus is applied and popped against the
// DUT outputs shortly after each input change. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                cpu_clk_50M = 1'b0;
    logic                cpu_rst_n;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DW-1:0]       wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD-1:0]      re;
    logic [NRD*DW-1:0]   rd;
    logic [NRD-1:0]      rd_pend;
    logic                issue_en;
    logic [AW-1:0]       issue_wa;
    logic                busy;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .ra          (ra),
        .re          (re),
        .rd          (rd),
        .rd_pend     (rd_pend),
        .issue_en    (issue_en),
        .issue_wa    (issue_wa),
        .busy        (busy)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    // kind: 0 = rd of port, 1 = rd_pend of port, 2 = busy
    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
    } item_t;

    item_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    n;

    task automatic cmp(input string t, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp);
        end
    endtask

    task automatic push(input string t, input int k, input int p, input logic [31:0] e);
        item_t it;
        it.kind = k;
        it.port = p;
        it.exp  = e;
        exp_q.push_back(it);
        tag_q.push_back(t);
    endtask

    task automatic exp_rd(input string t, input int p, input logic [31:0] e);
        push(t, 0, p, e);
    endtask

    task automatic exp_pend(input string t, input int p, input logic e);
        push(t, 1, p, {31'b0, e});
    endtask

    task automatic exp_busy(input string t, input logic e);
        push(t, 2, 0, {31'b0, e});
    endtask

    task automatic exp_all_zero(input string t);
        for (int p = 0; p < NRD; p++) begin
            exp_rd(t, p, 32'h0);
            exp_pend(t, p, 1'b0);
        end
    endtask

    task automatic check_now();
        item_t       it;
        string       t;
        logic [31:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            t  = tag_q.pop_front();
            case (it.kind)
                0:       obs = rd[it.port*DW +: DW];
                1:       obs = {31'b0, rd_pend[it.port]};
                default: obs = {31'b0, busy};
            endcase
            cmp(t, obs, it.exp);
        end
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_rst_n = 1'b0;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        ra        = '0;
        re        = '0;
        issue_en  = 1'b0;
        issue_wa  = '0;

        // ---- reset for two edges, then release and time the clear ----
        repeat (2) @(negedge cpu_clk_50M);
        re = 4'hF;
        set_ra(0, 5'd0); set_ra(1, 5'd1); set_ra(2, 5'd5); set_ra(3, 5'd31);
        exp_all_zero("reset_rd");
        exp_busy("reset_busy", 1'b1);
        check_now();

        cpu_rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge cpu_clk_50M);
            n++;
            if (n == 10) begin
                exp_all_zero("clear_rd");
                exp_busy("clear_busy", 1'b1);
                check_now();
            end
        end
        cmp("clear_cycles", n, 32);
        exp_all_zero("post_clear_rd");
        exp_busy("post_clear_busy", 1'b0);
        check_now();

        // ---- write r5 with a same-cycle read ----
        @(negedge cpu_clk_50M);
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        re = 4'b0011; set_ra(0, 5'd5); set_ra(1, 5'd5);
        exp_rd("bypass_p0", 0, BYP ? 32'hDEADBEEF : 32'h0);
        exp_rd("bypass_p1", 1, BYP ? 32'hDEADBEEF : 32'h0);
        exp_pend("bypass_pend", 0, 1'b0);
        check_now();
        @(negedge cpu_clk_50M);
        we = 1'b0;
        exp_rd("r5_next", 0, 32'hDEADBEEF);
        check_now();

        // ---- writes to r0 are discarded ----
        @(negedge cpu_clk_50M);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        re = 4'hF; ra = '0;
        exp_all_zero("r0_wr");
        check_now();
        @(negedge cpu_clk_50M);
        we = 1'b0;
        exp_all_zero("r0_rd");
        check_now();

        // ---- r7: no forwarding when we=0 ----
        @(negedge cpu_clk_50M);
        we = 1'b1; wa = 5'd7; wd = 32'h12345678;
        re = 4'b0001; set_ra(0, 5'd7);
        exp_rd("r7_wr", 0, BYP ? 32'h12345678 : 32'h0);
        check_now();
        @(negedge cpu_clk_50M);
        we = 1'b0; wa = 5'd7; wd = 32'hAAAA5555;
        exp_rd("r7_we0", 0, 32'h12345678);
        check_now();
        @(negedge cpu_clk_50M);
        exp_rd("r7_kept", 0, 32'h12345678);
        check_now();

        // ---- pending-write scoreboard on r9 ----
        @(negedge cpu_clk_50M);
        issue_en = 1'b1; issue_wa = 5'd9; set_ra(0, 5'd9);
        exp_pend("pend_issue_same", 0, 1'b0);
        check_now();
        @(negedge cpu_clk_50M);
        issue_en = 1'b0;
        exp_pend("pend_set", 0, 1'b1);
        check_now();
        @(negedge cpu_clk_50M);
        we = 1'b1; wa = 5'd9; wd = 32'h00000099;
        exp_pend("pend_wb_same", 0, BYP ? 1'b0 : 1'b1);
        exp_rd("r9_wb_same", 0, BYP ? 32'h00000099 : 32'h0);
        check_now();
        @(negedge cpu_clk_50M);
        we = 1'b0;
        exp_pend("pend_cleared", 0, 1'b0);
        exp_rd("r9_wb", 0, 32'h00000099);
        check_now();
        @(negedge cpu_clk_50M);
        issue_en = 1'b1; issue_wa = 5'd9;
        @(negedge cpu_clk_50M);
        issue_en = 1'b0;
        exp_pend("pend_reissue", 0, 1'b1);
        check_now();
        @(negedge cpu_clk_50M);
        issue_en = 1'b1; issue_wa = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'h00000077;
        exp_pend("pend_set_clr_same", 0, BYP ? 1'b0 : 1'b1);
        check_now();
        @(negedge cpu_clk_50M);
        issue_en = 1'b0; we = 1'b0;
        exp_pend("pend_set_wins", 0, 1'b1);
        exp_rd("r9_second", 0, 32'h00000077);
        check_now();

        // ---- four ports on r3 with sparse enables ----
        @(negedge cpu_clk_50M);
        we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; re = '0;
        @(negedge cpu_clk_50M);
        we = 1'b0;
        for (int p = 0; p < NRD; p++) set_ra(p, 5'd3);
        re = 4'b1010;
        exp_rd("en_p0", 0, 32'h0);
        exp_rd("en_p1", 1, 32'hCAFEF00D);
        exp_rd("en_p2", 2, 32'h0);
        exp_rd("en_p3", 3, 32'hCAFEF00D);
        for (int p = 0; p < NRD; p++) exp_pend("en_pend", p, 1'b0);
        check_now();

        // ---- reset from idle, then reset again mid-clear ----
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b0;
        re = 4'hF; set_ra(0, 5'd5); set_ra(1, 5'd9); set_ra(2, 5'd7); set_ra(3, 5'd3);
        exp_all_zero("rst_low_rd");
        exp_busy("rst_low_busy_pre", 1'b0);
        check_now();
        @(negedge cpu_clk_50M);
        exp_busy("rst_idle_busy", 1'b1);
        check_now();
        cpu_rst_n = 1'b1;
        we = 1'b1; wa = 5'd12; wd = 32'h5A5A5A5A;
        issue_en = 1'b1; issue_wa = 5'd12;
        repeat (10) @(negedge cpu_clk_50M);
        exp_busy("mid_clear_busy", 1'b1);
        check_now();
        cpu_rst_n = 1'b0;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge cpu_clk_50M);
            n++;
        end
        cmp("restart_cycles", n, 32);
        we = 1'b0; issue_en = 1'b0;
        set_ra(0, 5'd12); set_ra(1, 5'd5); set_ra(2, 5'd9); set_ra(3, 5'd3);
        exp_all_zero("after_restart");
        exp_busy("after_restart_busy", 1'b0);
        check_now();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port general-purpose register file for the MiniMIPS32 decode stage, successor to the fixed two-port file. It adds a configurable number of read ports, a write-enable-qualified write-to-read bypass, a post-reset sequential clear engine with a busy flag, and a per-register pending-write scoreboard so decode can detect operands whose producer has not yet written back.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width; depth `DEPTH = 2**ADDR_W`
- `NRD`, 2, number of read ports (1..4)
- `cpu_clk_50M` in 1: single clock, all state updates on rising edge
- `cpu_rst_n` in 1: synchronous, active-low reset
- `we` in 1: write enable
- `wa` in ADDR_W: write address
- `wd` in DATA_W: write data
- `ra` in NRD*ADDR_W: read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- `re` in NRD: read enables, bit i for port i
- `rd` out NRD*DATA_W: read data, port i at bits [i*DATA_W +: DATA_W]
- `rd_pend` out NRD: port i's operand has an outstanding producer
- `issue_en` in 1: an instruction writing `issue_wa` has been issued
- `issue_wa` in ADDR_W: destination of the issued instruction
- `busy` out 1: clear engine active; file unusable

## Operation
- Two-state FSM: CLEAR, IDLE. Clear index `clr_idx` (ADDR_W bits).
- Reset (edge with `cpu_rst_n`=0): state←CLEAR, `clr_idx`←0, all pending bits←0. Register contents unchanged by reset itself.
- CLEAR (edge with `cpu_rst_n`=1): regs[`clr_idx`]←0, `clr_idx`←`clr_idx`+1; at `clr_idx`=DEPTH-1 state←IDLE. No wrap beyond that.
- IDLE write: `we`=1 and `wa`≠0 → regs[`wa`]←`wd`. Writes to r0 discarded.
- Scoreboard in IDLE, per edge: `we`=1 clears pend[`wa`]; `issue_en`=1 and `issue_wa`≠0 sets pend[`issue_wa`]. Same address set and clear in one edge: set wins. pend[0] constant 0.
- Read port i (combinational, precedence top-down):
  - `busy`=1 or `cpu_rst_n`=0 → `rd`=0, `rd_pend`=0
  - `re[i]`=0 or `ra[i]`=0 → `rd`=0, `rd_pend`=0
  - bypass hit (`we`=1, `wa`=`ra[i]`, macro on) → `rd`=`wd`, `rd_pend`=0
  - else `rd`=regs[`ra[i]`], `rd_pend`=pend[`ra[i]`]
- `we` and `issue_en` ignored while `busy`=1.
- Ports independent; any number may read the same address.

## Timing
- Output reset values: `rd`=0, `rd_pend`=0, `busy`=1.
- `busy` = (state==CLEAR); registered, not a function of `cpu_rst_n`.
- After `cpu_rst_n` rises, `busy` stays high for exactly DEPTH cycles (32 at default), then 0.
- Reset asserted mid-clear: restarts at `clr_idx`=0, full DEPTH cycles again.
- Reset asserted in IDLE: pending bits cleared on that edge; registers re-zeroed by the following clear.
- Write latency: data visible on `rd` the cycle after the write edge; same cycle only via bypass.
- Scoreboard: `rd_pend` reflects an issue from the next cycle on; a pend cleared by a write is observed the next cycle (same cycle with bypass on).

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-to-read forwarding as above, qualified by `we`.
- Not defined: no forwarding; a read of the address being written returns the old stored value and the stored `rd_pend`; new value visible next cycle.

## Test plan
- Reset 2 cycles, release → `busy`=1 for 32 cycles then 0; every `ra` reads 0x00000000 during and after clear.
- IDLE, `we`=1 `wa`=5 `wd`=0xDEADBEEF, `ra[0]`=5 `re[0]`=1 same cycle → `rd[0]`=0xDEADBEEF with macro, 0x00000000 without; next cycle 0xDEADBEEF both.
- `we`=1 `wa`=0 `wd`=0xFFFFFFFF, then read r0 on all ports → 0; `we`=0 `wa`=7 while reading r7 → stored value, no bypass.
- `issue_en` `issue_wa`=9 → next cycle `rd_pend` for r9 =1; `we` `wa`=9 → cleared; simultaneous issue and write of r9 → stays 1.
- `NRD`=4, all ports reading r3 with `re`=4'b1010 → ports 1,3 return r3 value, ports 0,2 return 0.
- Pull `cpu_rst_n` low at clear cycle 10 for 1 cycle → `busy` high 32 cycles after release; writes attempted while busy not stored.
